regs_file_core: RTL and testbench

- General-purpose register file for the single-cycle/pipelined MIPS-style datapath: 32 registers × 32 bits.
- Provides two asynchronous (combinational) read ports, A for Rs/Rd and B for Rt.
- Provides one synchronous write port.
- Register 0 is hardwired to zero; the block sits between instruction decode and the ALU/writeback path.

---
 rtl/regs_file_core.sv | 76 +++++++
 tb/tb_regs_file_core.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/regs_file_core.sv
// Purpose  : 32 x 32 general-purpose register file, r0 hardwired to zero.
// Latency  : reads are combinational (0 cycles); writes commit on the rising clk edge.
// Backpres.: none; a write is accepted on every edge where we=1.
//
// Ports:
//   clk            - clock, all state changes on its rising edge
//   rst            - synchronous active-high reset, clears r1..r31, wins over we
//   we             - write enable
//   reg_Rd_addr_A  - read address, port A (Rs/Rd)
//   reg_Rt_addr_B  - read address, port B (Rt)
//   reg_Wt_addr    - write address (writes to 0 are dropped)
//   wdata          - write data
//   rdata_A/B      - read data for port A/B
//
// Build option: define REGS_WR_BYPASS_EN to forward wdata to a read port that
// addresses the register being written in the same cycle (never for r0, never
// while rst=1). Without it, reads return stored contents only.
module regs_file_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] reg_Rd_addr_A,
    input  logic [ADDR_W-1:0] reg_Rt_addr_B,
    input  logic [ADDR_W-1:0] reg_Wt_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_A,
    output logic [DATA_W-1:0] rdata_B
);

    localparam int NREGS = 2 ** ADDR_W;

    // Entry 0 exists only to keep the array indexable by any address; it is
    // never written outside reset and never read, so it optimises away.
    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (reg_Wt_addr != '0)) begin
            regs_q[reg_Wt_addr] <= wdata;
        end
    end

`ifdef REGS_WR_BYPASS_EN
    // A write that will actually land this edge; forwarded to matching readers
    // so decode sees the writeback value without waiting a cycle.
    logic wr_hit;
    assign wr_hit = !rst && we && (reg_Wt_addr != '0);
`endif

    always_comb begin
        rdata_A = '0;
        rdata_B = '0;
        if (reg_Rd_addr_A != '0) begin
            rdata_A = regs_q[reg_Rd_addr_A];
        end
        if (reg_Rt_addr_B != '0) begin
            rdata_B = regs_q[reg_Rt_addr_B];
        end
`ifdef REGS_WR_BYPASS_EN
        // wr_hit already excludes address 0, so r0 keeps reading zero.
        if (wr_hit && (reg_Rd_addr_A == reg_Wt_addr)) begin
            rdata_A = wdata;
        end
        if (wr_hit && (reg_Rt_addr_B == reg_Wt_addr)) begin
            rdata_B = wdata;
        end
`endif
    end

endmodule

// File: tb/tb_regs_file_core.sv
module tb_regs_file_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  reg_Rd_addr_A;
    logic [4:0]  reg_Rt_addr_B;
    logic [4:0]  reg_Wt_addr;
    logic [31:0] wdata;
    logic [31:0] rdata_A;
    logic [31:0] rdata_B;

    always #5 clk = ~clk;

    regs_file_core #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .we            (we),
        .reg_Rd_addr_A (reg_Rd_addr_A),
        .reg_Rt_addr_B (reg_Rt_addr_B),
        .reg_Wt_addr   (reg_Wt_addr),
        .wdata         (wdata),
        .rdata_A       (rdata_A),
        .rdata_B       (rdata_B)
    );

`ifdef REGS_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       nm;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [32];
    logic        mon_stb = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference read: register contents as of the last edge, r0 is zero,
    // optional same-cycle forwarding of a write that will land.
    function automatic logic [31:0] ref_rd(input logic [4:0] a, input logic r, input logic w,
                                           input logic [4:0] wt, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (BYP && !r && w && (wt != 5'd0) && (a == wt)) return wd;
        return model[a];
    endfunction

    // Monitor: each strobe means fresh inputs are applied; sample 1 time unit later.
    always @(mon_stb) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL monitor_underflow: no expectation queued at t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (rdata_A !== e.exp_a) begin
                n_fail++;
                $display("FAIL %s port_A addr=%0d got=%h expected=%h t=%0t",
                         e.nm, e.a, rdata_A, e.exp_a, $time);
            end
            n_checks++;
            if (rdata_B !== e.exp_b) begin
                n_fail++;
                $display("FAIL %s port_B addr=%0d got=%h expected=%h t=%0t",
                         e.nm, e.b, rdata_B, e.exp_b, $time);
            end
        end
    end

    // Apply one set of inputs, queue the expected reads, optionally clock an edge
    // and advance the model. Entered/left at posedge+1 when do_edge=1.
    task automatic drive(input string nm, input logic r, input logic w,
                         input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] wt, input logic [31:0] wd, input bit do_edge);
        exp_t e;
        rst = r; we = w; reg_Rd_addr_A = a; reg_Rt_addr_B = b;
        reg_Wt_addr = wt; wdata = wd;
        e.nm    = nm;
        e.a     = a;
        e.b     = b;
        e.exp_a = ref_rd(a, r, w, wt, wd);
        e.exp_b = ref_rd(b, r, w, wt, wd);
        exp_q.push_back(e);
        mon_stb = ~mon_stb;
        #2;
        if (do_edge) begin
            @(posedge clk);
            if (r) begin
                for (int i = 0; i < 32; i++) model[i] = 32'h0;
            end else if (w && (wt != 5'd0)) begin
                model[wt] = wd;
            end
            #1;
        end
    endtask

    initial begin
        logic       r, w;
        logic [4:0] a, b, wt;

        // Power-on contents are undefined: reset before any check.
        rst = 1'b1; we = 1'b0; reg_Rd_addr_A = '0; reg_Rt_addr_B = '0;
        reg_Wt_addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset state on every address.
        for (int i = 0; i < 32; i++)
            drive("reset_state", 1'b0, 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b1);

        // Fill r1..r31 with ones, then reset with a concurrent write.
        for (int i = 1; i < 32; i++)
            drive("fill_ones", 1'b0, 1'b1, 5'(i), 5'(i - 1), 5'(i), 32'hFFFF_FFFF, 1'b1);
        drive("reset_with_we", 1'b1, 1'b1, 5'd9, 5'd3, 5'd9, 32'h1234_5678, 1'b1);
        for (int i = 0; i < 32; i++)
            drive("after_reset", 1'b0, 1'b0, 5'(i), 5'(31 - i), 5'd9, 32'h0, 1'b1);

        // Basic write/read.
        drive("wr_r5", 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hA5A5_A5A5, 1'b1);
        drive("wr_r6", 1'b0, 1'b1, 5'd0, 5'd0, 5'd6, 32'h55AA_55AA, 1'b1);
        drive("rd_r5_r6", 1'b0, 1'b0, 5'd5, 5'd6, 5'd0, 32'h0, 1'b1);

        // Writes to r0 are discarded.
        drive("wr_r0", 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hAAAA_5555, 1'b1);
        drive("rd_r0", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
        drive("rd_r5_r6_after_r0", 1'b0, 1'b0, 5'd5, 5'd6, 5'd0, 32'h0, 1'b1);

        // we=0 keeps r5.
        repeat (3) drive("we_low", 1'b0, 1'b0, 5'd5, 5'd6, 5'd5, 32'h1234_5678, 1'b1);

        // Read-during-write on r7 (zero beforehand).
        drive("rdw_pre_edge", 1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 32'hDEAD_BEEF, 1'b1);
        drive("rdw_post_edge", 1'b0, 1'b0, 5'd7, 5'd7, 5'd0, 32'h0, 1'b1);

        // Bypass must not reach r0 and must be suppressed during reset.
        drive("wr_r0_read_r0", 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hCAFE_F00D, 1'b1);

        // Same address on both ports, then a combinational address change.
        drive("dual_same_addr", 1'b0, 1'b0, 5'd6, 5'd6, 5'd0, 32'h0, 1'b0);
        drive("comb_addr_change", 1'b0, 1'b0, 5'd5, 5'd6, 5'd0, 32'h0, 1'b0);
        @(posedge clk);
        #1;

        // Randomised traffic, with forced read/write address collisions.
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 49) == 0);
            w  = ($urandom_range(0, 3) != 0);
            wt = 5'($urandom_range(0, 31));
            a  = ($urandom_range(0, 3) == 0) ? wt : 5'($urandom_range(0, 31));
            b  = ($urandom_range(0, 3) == 0) ? wt : 5'($urandom_range(0, 31));
            drive("random", r, w, a, b, wt, $urandom, 1'b1);
        end

        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
